// File: rtl/bit_position_vector_builder.sv
// Rebuilds a WIDTH-bit vector from a stream of bit positions, one frame per pos_last.
// Optional macro BVPB_DUP_CHECK_EN: a repeated position within a frame also raises vec_err.
module bit_position_vector_builder #(
  parameter int   WIDTH    = 32,
  parameter int   POS_W    = 6,
  parameter logic MARK_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pos_valid,
  output logic             pos_ready,
  input  logic [POS_W-1:0] pos_data,
  input  logic             pos_last,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [WIDTH-1:0] vec_data,
  output logic [POS_W-1:0] vec_count,
  output logic             vec_err
);

  // state | meaning
  // IDLE  | no beat of the current frame accepted yet
  // ACCUM | frame in progress, last beat not yet seen
  // HOLD  | frame complete, vector offered downstream
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [POS_W-1:0] POS_NONE = POS_W'(WIDTH);
  localparam logic [WIDTH-1:0] UNMARKED = {WIDTH{~MARK_VAL}};

  state_t           state;
  logic             beat_acc;
  logic [IDX_W-1:0] idx;
  logic             is_bit;
  logic             is_illegal;
  logic             already;
  logic             dup_err;

  // Ready drops immediately while reset is held so no beat is taken during reset.
  assign pos_ready  = rst_n && (state != HOLD);
  assign beat_acc   = pos_valid && pos_ready;
  assign idx        = pos_data[IDX_W-1:0];
  assign is_bit     = (pos_data < POS_NONE);
  assign is_illegal = (pos_data > POS_NONE);
  assign already    = (vec_data[idx] == MARK_VAL);

`ifdef BVPB_DUP_CHECK_EN
  assign dup_err = is_bit && already;
`else
  assign dup_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec_valid <= 1'b0;
      vec_data  <= UNMARKED;
      vec_count <= '0;
      vec_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (beat_acc) begin
            if (is_bit) begin
              vec_data[idx] <= MARK_VAL;
              if (!already && (vec_count != POS_NONE))
                vec_count <= vec_count + POS_W'(1);
            end
            if (is_illegal || dup_err)
              vec_err <= 1'b1;
            state     <= pos_last ? HOLD : ACCUM;
            vec_valid <= pos_last;
          end
        end
        HOLD: begin
          if (vec_ready) begin
            state     <= IDLE;
            vec_valid <= 1'b0;
            vec_data  <= UNMARKED;
            vec_count <= '0;
            vec_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          vec_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_position_vector_builder.sv
// Self-checking bench for bit_position_vector_builder (WIDTH=32, MARK_VAL=0).
module tb_bit_position_vector_builder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pos_valid = 1'b0;
  logic        pos_ready;
  logic [5:0]  pos_data = '0;
  logic        pos_last = 1'b0;
  logic        vec_valid;
  logic        vec_ready = 1'b0;
  logic [31:0] vec_data;
  logic [5:0]  vec_count;
  logic        vec_err;

  int total = 0;
  int bad = 0;

  bit marked [32];
  int m_cnt;
  bit m_err;

  bit_position_vector_builder #(.WIDTH(32), .POS_W(6), .MARK_VAL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .pos_data(pos_data), .pos_last(pos_last), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_data(vec_data), .vec_count(vec_count),
    .vec_err(vec_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    int          p [3];
    logic [31:0] d;
    int          c;
    bit          e;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) marked[i] = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic model_apply(input int p);
    if (p < 32) begin
`ifdef BVPB_DUP_CHECK_EN
      if (marked[p]) m_err = 1'b1;
`endif
      if (!marked[p]) m_cnt++;
      marked[p] = 1'b1;
    end else if (p > 32) begin
      m_err = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = marked[i] ? 1'b0 : 1'b1;
    return v;
  endfunction

  // Lowest-zero detector: index of the first bit equal to 0, 32 if none.
  function automatic int lowest_zero(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i] == 1'b0) return i;
    return 32;
  endfunction

  task automatic beat(input int p, input bit l);
    chk("beat_ready", 64'(pos_ready), 64'd1);
    pos_valid = 1'b1;
    pos_data  = 6'(p);
    pos_last  = l;
    @(posedge clk);
    #1;
    pos_valid = 1'b0;
    pos_last  = 1'b0;
    model_apply(p);
  endtask

  task automatic handshake();
    vec_ready = 1'b1;
    @(posedge clk);
    #1;
    vec_ready = 1'b0;
    chk("hs_valid", 64'(vec_valid), 64'd0);
    chk("hs_ready", 64'(pos_ready), 64'd1);
    chk("hs_data", 64'(vec_data), 64'hFFFF_FFFF);
    chk("hs_count", 64'(vec_count), 64'd0);
    chk("hs_err", 64'(vec_err), 64'd0);
    model_clear();
  endtask

  vec_t tbl [4];
  logic [31:0] held;

  initial begin
    tbl[0] = '{n: 2, p: '{3, 7, 0},   d: 32'hFFFF_FF77, c: 2, e: 1'b0};
    tbl[1] = '{n: 1, p: '{32, 0, 0},  d: 32'hFFFF_FFFF, c: 0, e: 1'b0};
    tbl[2] = '{n: 3, p: '{6, 40, 1},  d: 32'hFFFF_FFBD, c: 2, e: 1'b1};
`ifdef BVPB_DUP_CHECK_EN
    tbl[3] = '{n: 2, p: '{5, 5, 0},   d: 32'hFFFF_FFDF, c: 1, e: 1'b1};
`else
    tbl[3] = '{n: 2, p: '{5, 5, 0},   d: 32'hFFFF_FFDF, c: 1, e: 1'b0};
`endif

    model_clear();
    #12;
    chk("rst_ready_low", 64'(pos_ready), 64'd0);
    chk("rst_valid", 64'(vec_valid), 64'd0);
    chk("rst_data", 64'(vec_data), 64'hFFFF_FFFF);
    chk("rst_count", 64'(vec_count), 64'd0);
    chk("rst_err", 64'(vec_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", 64'(pos_ready), 64'd1);

    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < tbl[t].n; b++) begin
        chk("tbl_pre_valid", 64'(vec_valid), 64'd0);
        beat(tbl[t].p[b], b == tbl[t].n - 1);
      end
      chk("tbl_valid", 64'(vec_valid), 64'd1);
      chk("tbl_ready_hold", 64'(pos_ready), 64'd0);
      chk("tbl_data", 64'(vec_data), 64'(tbl[t].d));
      chk("tbl_count", 64'(vec_count), 64'(tbl[t].c));
      chk("tbl_err", 64'(vec_err), 64'(tbl[t].e));
      if (t == 0) chk("tbl_detector", 64'(lowest_zero(vec_data)), 64'd3);
      handshake();
    end

    // Consumer stalls in HOLD, then a new frame right after release.
    beat(10, 1'b0);
    beat(20, 1'b1);
    held = vec_data;
    chk("stall_data0", 64'(held), 64'hFFEF_FBFF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_ready", 64'(pos_ready), 64'd0);
      chk("stall_valid", 64'(vec_valid), 64'd1);
      chk("stall_data", 64'(vec_data), 64'(held));
      chk("stall_count", 64'(vec_count), 64'd2);
    end
    handshake();
    beat(0, 1'b1);
    chk("post_stall_data", 64'(vec_data), 64'hFFFF_FFFE);
    chk("post_stall_count", 64'(vec_count), 64'd1);
    handshake();

    // Reset mid-frame discards the partial vector.
    beat(2, 1'b0);
    beat(9, 1'b0);
    chk("mid_live_data", 64'(vec_data), 64'hFFFF_FDFB);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ready", 64'(pos_ready), 64'd0);
    chk("mrst_valid", 64'(vec_valid), 64'd0);
    chk("mrst_data", 64'(vec_data), 64'hFFFF_FFFF);
    chk("mrst_count", 64'(vec_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    beat(4, 1'b1);
    chk("mrst_next_data", 64'(vec_data), 64'hFFFF_FFEF);
    chk("mrst_next_count", 64'(vec_count), 64'd1);
    handshake();

    // Randomized frames against the reference model.
    for (int f = 0; f < 40; f++) begin
      int nb;
      nb = $urandom_range(1, 40);
      for (int b = 0; b < nb; b++) begin
        int p;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        p = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 40);
        beat(p, b == nb - 1);
        chk("rnd_live_data", 64'(vec_data), 64'(model_vec()));
      end
      chk("rnd_valid", 64'(vec_valid), 64'd1);
      chk("rnd_data", 64'(vec_data), 64'(model_vec()));
      chk("rnd_count", 64'(vec_count), 64'(m_cnt));
      chk("rnd_err", 64'(vec_err), 64'(m_err));
      for (int w = $urandom_range(0, 3); w > 0; w--) begin
        @(posedge clk);
        #1;
        chk("rnd_hold_data", 64'(vec_data), 64'(model_vec()));
        chk("rnd_hold_ready", 64'(pos_ready), 64'd0);
      end
      handshake();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
